stopwatch_core: RTL and testbench

Parametrised MM:SS BCD stopwatch counter. It replaces the fixed four-digit counter between the clock divider/debouncers and the seven-segment display driver. It adds pause toggling, synchronous clear, per-digit adjust loading, configurable minute range, and wrap-or-saturate overflow. An optional lap-capture register can be compiled in.

---
 rtl/stopwatch_core.sv | 206 ++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with pause toggle, clear, per-digit adjust and wrap/saturate overflow.
// Optional lap-capture register enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int unsigned MIN_TENS_MAX  = 9,
  parameter int unsigned WRAP          = 1,
  parameter int unsigned START_RUNNING = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       adj_tick,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       btn_lap,
  input  logic       adj,
  input  logic [1:0] sel,
  input  logic [3:0] num,
  output logic [3:0] min_l,
  output logic [3:0] min_r,
  output logic [3:0] sec_l,
  output logic [3:0] sec_r,
  output logic       running,
  output logic       overflow,
  output logic       lap_valid,
  output logic [3:0] lap_min_l,
  output logic [3:0] lap_min_r,
  output logic [3:0] lap_sec_l,
  output logic [3:0] lap_sec_r
);

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } run_state_t;

  localparam logic [3:0] MIN_L_MAX   = 4'(MIN_TENS_MAX);
  localparam run_state_t RESET_STATE = (START_RUNNING != 0) ? ST_RUN : ST_PAUSE;

  run_state_t state_q, state_d;
  logic [3:0] sec_r_q, sec_r_d;
  logic [3:0] sec_l_q, sec_l_d;
  logic [3:0] min_r_q, min_r_d;
  logic [3:0] min_l_q, min_l_d;
  logic       overflow_q, overflow_d;

  logic [3:0] clamp_max;
  logic [3:0] num_clamped;
  logic       at_max;
  logic       do_load;
  logic       do_count;

  always_comb begin
    state_d    = state_q;
    sec_r_d    = sec_r_q;
    sec_l_d    = sec_l_q;
    min_r_d    = min_r_q;
    min_l_d    = min_l_q;
    overflow_d = (WRAP != 0) ? 1'b0 : overflow_q;

    case (sel)
      2'd0:    clamp_max = 4'd9;
      2'd1:    clamp_max = 4'd5;
      2'd2:    clamp_max = 4'd9;
      default: clamp_max = MIN_L_MAX;
    endcase
    num_clamped = (num > clamp_max) ? clamp_max : num;

    at_max   = (sec_r_q == 4'd9) && (sec_l_q == 4'd5) &&
               (min_r_q == 4'd9) && (min_l_q == MIN_L_MAX);
    do_load  = adj && adj_tick;
    // Tick uses the pre-toggle run state; a saturated counter ignores ticks.
    do_count = !adj && tick && (state_q == ST_RUN) &&
               !((WRAP == 0) && overflow_q);

    if (!adj && btn_pause)
      state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;

    if (btn_reset) begin
      sec_r_d    = '0;
      sec_l_d    = '0;
      min_r_d    = '0;
      min_l_d    = '0;
      overflow_d = 1'b0;
    end else if (do_load) begin
      case (sel)
        2'd0:    sec_r_d = num_clamped;
        2'd1:    sec_l_d = num_clamped;
        2'd2:    min_r_d = num_clamped;
        default: min_l_d = num_clamped;
      endcase
    end else if (do_count) begin
      if (at_max) begin
        overflow_d = 1'b1;
        if (WRAP != 0) begin
          sec_r_d = '0;
          sec_l_d = '0;
          min_r_d = '0;
          min_l_d = '0;
        end
      end else if (sec_r_q != 4'd9) begin
        sec_r_d = sec_r_q + 4'd1;
      end else begin
        sec_r_d = '0;
        if (sec_l_q != 4'd5) begin
          sec_l_d = sec_l_q + 4'd1;
        end else begin
          sec_l_d = '0;
          if (min_r_q != 4'd9) begin
            min_r_d = min_r_q + 4'd1;
          end else begin
            min_r_d = '0;
            min_l_d = min_l_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      sec_r_q    <= '0;
      sec_l_q    <= '0;
      min_r_q    <= '0;
      min_l_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_r_q    <= sec_r_d;
      sec_l_q    <= sec_l_d;
      min_r_q    <= min_r_d;
      min_l_q    <= min_l_d;
      overflow_q <= overflow_d;
    end
  end

  assign sec_r    = sec_r_q;
  assign sec_l    = sec_l_q;
  assign min_r    = min_r_q;
  assign min_l    = min_l_q;
  assign running  = (state_q == ST_RUN);
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic       lap_valid_q, lap_valid_d;
  logic [3:0] lap_sec_r_q, lap_sec_r_d;
  logic [3:0] lap_sec_l_q, lap_sec_l_d;
  logic [3:0] lap_min_r_q, lap_min_r_d;
  logic [3:0] lap_min_l_q, lap_min_l_d;

  // Capture samples the current registers, i.e. the pre-increment time.
  always_comb begin
    lap_valid_d = lap_valid_q;
    lap_sec_r_d = lap_sec_r_q;
    lap_sec_l_d = lap_sec_l_q;
    lap_min_r_d = lap_min_r_q;
    lap_min_l_d = lap_min_l_q;
    if (btn_lap) begin
      if (!lap_valid_q) begin
        lap_valid_d = 1'b1;
        lap_sec_r_d = sec_r_q;
        lap_sec_l_d = sec_l_q;
        lap_min_r_d = min_r_q;
        lap_min_l_d = min_l_q;
      end else begin
        lap_valid_d = 1'b0;
        lap_sec_r_d = '0;
        lap_sec_l_d = '0;
        lap_min_r_d = '0;
        lap_min_l_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_valid_q <= 1'b0;
      lap_sec_r_q <= '0;
      lap_sec_l_q <= '0;
      lap_min_r_q <= '0;
      lap_min_l_q <= '0;
    end else begin
      lap_valid_q <= lap_valid_d;
      lap_sec_r_q <= lap_sec_r_d;
      lap_sec_l_q <= lap_sec_l_d;
      lap_min_r_q <= lap_min_r_d;
      lap_min_l_q <= lap_min_l_d;
    end
  end

  assign lap_valid = lap_valid_q;
  assign lap_sec_r = lap_sec_r_q;
  assign lap_sec_l = lap_sec_l_q;
  assign lap_min_r = lap_min_r_q;
  assign lap_min_l = lap_min_l_q;
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;
  assign lap_valid      = 1'b0;
  assign lap_sec_r      = '0;
  assign lap_sec_l      = '0;
  assign lap_min_r      = '0;
  assign lap_min_l      = '0;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a wrapping instance plus a saturating instance on shared inputs.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, adj_tick, btn_pause, btn_reset, btn_lap, adj;
  logic [1:0] sel;
  logic [3:0] num;

  logic [3:0] min_l, min_r, sec_l, sec_r;
  logic       running, overflow, lap_valid;
  logic [3:0] lap_min_l, lap_min_r, lap_sec_l, lap_sec_r;

  logic [3:0] s_min_l, s_min_r, s_sec_l, s_sec_r;
  logic       s_running, s_overflow, s_lap_valid;
  logic [3:0] s_lap_min_l, s_lap_min_r, s_lap_sec_l, s_lap_sec_r;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.MIN_TENS_MAX(9), .WRAP(1), .START_RUNNING(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
    .btn_pause(btn_pause), .btn_reset(btn_reset), .btn_lap(btn_lap),
    .adj(adj), .sel(sel), .num(num),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .running(running), .overflow(overflow), .lap_valid(lap_valid),
    .lap_min_l(lap_min_l), .lap_min_r(lap_min_r),
    .lap_sec_l(lap_sec_l), .lap_sec_r(lap_sec_r)
  );

  stopwatch_core #(.MIN_TENS_MAX(9), .WRAP(0), .START_RUNNING(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
    .btn_pause(btn_pause), .btn_reset(btn_reset), .btn_lap(btn_lap),
    .adj(adj), .sel(sel), .num(num),
    .min_l(s_min_l), .min_r(s_min_r), .sec_l(s_sec_l), .sec_r(s_sec_r),
    .running(s_running), .overflow(s_overflow), .lap_valid(s_lap_valid),
    .lap_min_l(s_lap_min_l), .lap_min_r(s_lap_min_r),
    .lap_sec_l(s_lap_sec_l), .lap_sec_r(s_lap_sec_r)
  );

  logic [15:0] t_main, t_sat, t_lap;
  assign t_main = {min_l, min_r, sec_l, sec_r};
  assign t_sat  = {s_min_l, s_min_r, s_sec_l, s_sec_r};
  assign t_lap  = {lap_min_l, lap_min_r, lap_sec_l, lap_sec_r};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic pulse_pause();
    btn_pause = 1'b1;
    step();
    btn_pause = 1'b0;
  endtask

  task automatic pulse_reset();
    btn_reset = 1'b1;
    step();
    btn_reset = 1'b0;
  endtask

  task automatic load(input logic [1:0] s, input logic [3:0] v);
    sel      = s;
    num      = v;
    adj_tick = 1'b1;
    step();
    adj_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; adj_tick = 1'b0; btn_pause = 1'b0;
    btn_reset = 1'b0; btn_lap = 1'b0; adj = 1'b0; sel = 2'd0; num = 4'd0;
    step();
    step();
    check("reset_time", 32'(t_main), 32'h0000);
    check("reset_running", 32'(running), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_lap_valid", 32'(lap_valid), 32'd0);
    check("reset_lap_time", 32'(t_lap), 32'h0000);
    rst_n = 1'b1;

    do_ticks(2);
    check("paused_no_count", 32'(t_main), 32'h0000);
    pulse_pause();
    check("pause_toggle_run", 32'(running), 32'd1);
    do_ticks(75);
    check("count_75", 32'(t_main), 32'h0115);
    do_ticks(3524);
    check("count_5959", 32'(t_main), 32'h5959);
    do_ticks(1);
    check("count_6000", 32'(t_main), 32'h6000);

    // Preload 99:59 on both instances
    adj = 1'b1;
    load(2'd3, 4'd9);
    load(2'd2, 4'd9);
    load(2'd1, 4'd5);
    load(2'd0, 4'd9);
    adj = 1'b0;
    check("preload_9959", 32'(t_main), 32'h9959);
    do_ticks(1);
    check("wrap_time", 32'(t_main), 32'h0000);
    check("wrap_ovf_pulse", 32'(overflow), 32'd1);
    check("sat_time", 32'(t_sat), 32'h9959);
    check("sat_ovf", 32'(s_overflow), 32'd1);
    step();
    check("wrap_ovf_drop", 32'(overflow), 32'd0);
    check("sat_ovf_hold", 32'(s_overflow), 32'd1);
    do_ticks(2);
    check("wrap_after_count", 32'(t_main), 32'h0002);
    check("sat_ignores_tick", 32'(t_sat), 32'h9959);
    pulse_reset();
    check("sat_clear_time", 32'(t_sat), 32'h0000);
    check("sat_clear_ovf", 32'(s_overflow), 32'd0);
    check("clear_keeps_run", 32'(running), 32'd1);

    // Adjust with clamping; ticks and pause ignored
    adj = 1'b1;
    load(2'd1, 4'd8);
    check("adj_clamp_sec_l", 32'(t_main), 32'h0050);
    load(2'd3, 4'd15);
    check("adj_clamp_min_l", 32'(t_main), 32'h9050);
    load(2'd0, 4'd12);
    check("adj_clamp_sec_r", 32'(t_main), 32'h9059);
    load(2'd2, 4'd4);
    check("adj_load_min_r", 32'(t_main), 32'h9459);
    do_ticks(3);
    check("adj_ignores_tick", 32'(t_main), 32'h9459);
    pulse_pause();
    check("adj_ignores_pause", 32'(running), 32'd1);
    adj = 1'b0;
    do_ticks(1);
    check("resume_after_adj", 32'(t_main), 32'h9500);

    // Same-cycle events
    pulse_reset();
    do_ticks(3);
    tick = 1'b1; btn_reset = 1'b1;
    step();
    tick = 1'b0; btn_reset = 1'b0;
    check("reset_beats_tick", 32'(t_main), 32'h0000);
    tick = 1'b1; btn_pause = 1'b1;
    step();
    tick = 1'b0; btn_pause = 1'b0;
    check("pause_tick_count", 32'(t_main), 32'h0001);
    check("pause_tick_state", 32'(running), 32'd0);
    do_ticks(2);
    check("paused_hold", 32'(t_main), 32'h0001);
    load(2'd0, 4'd7);
    check("adj_tick_no_adj", 32'(t_main), 32'h0001);
    adj = 1'b1; btn_reset = 1'b1;
    load(2'd0, 4'd7);
    adj = 1'b0; btn_reset = 1'b0;
    check("reset_beats_load", 32'(t_main), 32'h0000);

    // Asynchronous reset at 12:34
    adj = 1'b1;
    load(2'd3, 4'd1);
    load(2'd2, 4'd2);
    load(2'd1, 4'd3);
    load(2'd0, 4'd4);
    adj = 1'b0;
    pulse_pause();
    check("pre_async_time", 32'(t_main), 32'h1234);
    check("pre_async_run", 32'(running), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_time", 32'(t_main), 32'h0000);
    check("async_running", 32'(running), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    pulse_pause();
    do_ticks(1);
    check("post_reset_tick", 32'(t_main), 32'h0001);

`ifdef STOPWATCH_LAP_EN
    pulse_reset();
    do_ticks(7);
    check("lap_pre", 32'(t_main), 32'h0007);
    tick = 1'b1; btn_lap = 1'b1;
    step();
    tick = 1'b0; btn_lap = 1'b0;
    check("lap_capture", 32'(t_lap), 32'h0007);
    check("lap_valid_set", 32'(lap_valid), 32'd1);
    do_ticks(2);
    check("lap_count_on", 32'(t_main), 32'h0010);
    check("lap_held", 32'(t_lap), 32'h0007);
    btn_lap = 1'b1;
    step();
    btn_lap = 1'b0;
    check("lap_clear_valid", 32'(lap_valid), 32'd0);
    check("lap_clear_time", 32'(t_lap), 32'h0000);
`else
    btn_lap = 1'b1;
    step();
    btn_lap = 1'b0;
    check("nolap_valid", 32'(lap_valid), 32'd0);
    check("nolap_time", 32'(t_lap), 32'h0000);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
